// File: rtl/sweep_controller.sv
// sweep_controller
//   Up/down sweep sequencer. An IDLE/UP/DOWN/HOLD state machine steps an
//   internal WIDTH-bit counter between 0 and TOP. A dwell prescaler sets how
//   many clocks each count step takes. Sits between the debounced push-button
//   front end and the VGA pattern/colour logic.
//
//   Parameters:
//     WIDTH  counter width in bits (>= 2)
//     TOP    sweep upper limit, 1 <= TOP <= 2^WIDTH-1
//     DWELL  clock cycles per count step (>= 1)
//
//   Ports:
//     clk          system clock, rising edge
//     reset        asynchronous active-low reset
//     start        begin a sweep from 0 (level, honoured in IDLE and HOLD)
//     progressive  request upward sweep
//     regressive   request downward sweep
//     stop         freeze the sweep in HOLD
//     count        current sweep value (registered)
//     state        00 IDLE, 01 UP, 10 DOWN, 11 HOLD (registered)
//     busy         high while in UP or DOWN (registered)
//     done         one-cycle pulse when a DOWN sweep steps onto 0 (registered)
//
//   Build option:
//     SWEEP_AUTO_REPEAT_EN  when defined, a DOWN step onto 0 turns straight
//                           back to UP (continuous triangle sweep) instead of
//                           parking in HOLD; done still pulses at each 0.
module sweep_controller #(
    parameter int WIDTH = 4,
    parameter int TOP   = 15,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             progressive,
    input  logic             regressive,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    localparam int PW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;
    localparam logic [1:0] ST_HOLD = 2'b11;

`ifdef SWEEP_AUTO_REPEAT_EN
    localparam logic [1:0] ST_AT_ZERO = ST_UP;
`else
    localparam logic [1:0] ST_AT_ZERO = ST_HOLD;
`endif

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_TOP  = WIDTH'(TOP);
    localparam logic [PW-1:0]    PRE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DWELL - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic [PW-1:0]    pre_r;
    logic [PW-1:0]    pre_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             run_s;
    logic             tick_s;

    assign run_s  = (state_r == ST_UP) || (state_r == ST_DOWN);
    assign tick_s = run_s && (pre_r == PRE_LAST);

    // State, counter, prescaler and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
            pre_r   <= PRE_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            pre_r   <= pre_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next state and next count: stop beats a direction request, which beats a step.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_UP;
                    count_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_nxt_s = ST_HOLD;
                end else if (regressive && !progressive) begin
                    state_nxt_s = ST_DOWN;
                end else if (tick_s) begin
                    // Already at TOP (reached by reversing out of DOWN at TOP):
                    // turn around without stepping so count cannot pass TOP.
                    if (count_r >= CNT_TOP) begin
                        state_nxt_s = ST_DOWN;
                    end else begin
                        count_nxt_s = count_r + CNT_ONE;
                        if (count_r == (CNT_TOP - CNT_ONE)) begin
                            state_nxt_s = ST_DOWN;
                        end else begin
                            state_nxt_s = ST_UP;
                        end
                    end
                end else begin
                    state_nxt_s = ST_UP;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_nxt_s = ST_HOLD;
                end else if (progressive) begin
                    state_nxt_s = ST_UP;
                end else if (tick_s) begin
                    // Already at 0 (entered DOWN by reversal at 0): park in HOLD
                    // without stepping; this is not a completed sweep, so no done.
                    if (count_r == CNT_ZERO) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        count_nxt_s = count_r - CNT_ONE;
                        if (count_r == CNT_ONE) begin
                            state_nxt_s = ST_AT_ZERO;
                            done_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_DOWN;
                        end
                    end
                end else begin
                    state_nxt_s = ST_DOWN;
                end
            end
            ST_HOLD: begin
                if (start) begin
                    state_nxt_s = ST_UP;
                    count_nxt_s = CNT_ZERO;
                end else if (progressive && (count_r < CNT_TOP)) begin
                    state_nxt_s = ST_UP;
                end else if (regressive && (count_r > CNT_ZERO)) begin
                    state_nxt_s = ST_DOWN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Prescaler and busy for the coming cycle, derived from the chosen next state.
    always_comb begin
        pre_nxt_s  = PRE_ZERO;
        busy_nxt_s = (state_nxt_s == ST_UP) || (state_nxt_s == ST_DOWN);
        // The prescaler only runs while staying in UP/DOWN; any state change restarts it.
        if (busy_nxt_s && (state_nxt_s == state_r)) begin
            if (tick_s) begin
                pre_nxt_s = PRE_ZERO;
            end else begin
                pre_nxt_s = pre_r + PRE_ONE;
            end
        end else begin
            pre_nxt_s = PRE_ZERO;
        end
    end

    assign count = count_r;
    assign state = state_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller. Four instances with different TOP/DWELL share one
// set of inputs; each has its own copy of a behavioural model that is checked
// every cycle, plus directed expectations for the sweep scenarios.
module tb_sweep_controller;

    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_DN   = 2;
    localparam int S_HOLD = 3;
    localparam int NDUT   = 4;

`ifdef SWEEP_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic progressive = 1'b0;
    logic regressive  = 1'b0;
    logic stop  = 1'b0;

    logic [3:0] cnt [NDUT];
    logic [1:0] st  [NDUT];
    logic       bsy [NDUT];
    logic       dn  [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    int m_st   [NDUT];
    int m_cnt  [NDUT];
    int m_pre  [NDUT];
    int m_done [NDUT];

    always #5 clk = ~clk;

    sweep_controller #(.WIDTH(4), .TOP(15), .DWELL(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .progressive(progressive),
        .regressive(regressive), .stop(stop),
        .count(cnt[0]), .state(st[0]), .busy(bsy[0]), .done(dn[0]));
    sweep_controller #(.WIDTH(4), .TOP(15), .DWELL(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .progressive(progressive),
        .regressive(regressive), .stop(stop),
        .count(cnt[1]), .state(st[1]), .busy(bsy[1]), .done(dn[1]));
    sweep_controller #(.WIDTH(4), .TOP(9), .DWELL(3)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .progressive(progressive),
        .regressive(regressive), .stop(stop),
        .count(cnt[2]), .state(st[2]), .busy(bsy[2]), .done(dn[2]));
    sweep_controller #(.WIDTH(4), .TOP(3), .DWELL(1)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .progressive(progressive),
        .regressive(regressive), .stop(stop),
        .count(cnt[3]), .state(st[3]), .busy(bsy[3]), .done(dn[3]));

    function automatic int top_of(input int i);
        case (i)
            0: return 15;
            1: return 15;
            2: return 9;
            default: return 3;
        endcase
    endfunction

    function automatic int dwell_of(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_st[i] = S_IDLE; m_cnt[i] = 0; m_pre[i] = 0; m_done[i] = 0;
        end
    endtask

    // One clock of the sweep rules for instance i, evaluated on integers.
    task automatic model_step(input int i);
        int  s, c, ns, nc, nd, tp;
        bit  tick;
        s = m_st[i]; c = m_cnt[i]; tp = top_of(i);
        ns = s; nc = c; nd = 0;
        tick = ((s == S_UP) || (s == S_DN)) && (m_pre[i] == dwell_of(i) - 1);
        case (s)
            S_IDLE: begin
                if (start) begin ns = S_UP; nc = 0; end
            end
            S_UP: begin
                if (stop) ns = S_HOLD;
                else if (regressive && !progressive) ns = S_DN;
                else if (tick) begin
                    if (c < tp) nc = c + 1;
                    if (nc == tp) ns = S_DN;
                end
            end
            S_DN: begin
                if (stop) ns = S_HOLD;
                else if (progressive) ns = S_UP;
                else if (tick) begin
                    if (c > 0) begin nc = c - 1; nd = (nc == 0) ? 1 : 0; end
                    if (nc == 0) ns = (nd == 1 && AUTO) ? S_UP : S_HOLD;
                end
            end
            default: begin
                if (start) begin ns = S_UP; nc = 0; end
                else if (progressive && c < tp) ns = S_UP;
                else if (regressive && c > 0) ns = S_DN;
            end
        endcase
        if (ns == s && (ns == S_UP || ns == S_DN)) m_pre[i] = tick ? 0 : m_pre[i] + 1;
        else m_pre[i] = 0;
        m_st[i] = ns; m_cnt[i] = nc; m_done[i] = nd;
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("dut%0d state", i), int'(st[i]), m_st[i]);
            chk($sformatf("dut%0d count", i), int'(cnt[i]), m_cnt[i]);
            chk($sformatf("dut%0d busy", i), int'(bsy[i]),
                (m_st[i] == S_UP || m_st[i] == S_DN) ? 1 : 0);
            chk($sformatf("dut%0d done", i), int'(dn[i]), m_done[i]);
        end
    endtask

    // Advance one clock: model first, then sample the DUTs 1 ns after the edge.
    task automatic cyc();
        for (int i = 0; i < NDUT; i++) model_step(i);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Called 1 ns after an edge: reset lands between edges and takes effect at once.
    task automatic do_async_reset();
        #3 reset = 1'b0;
        #1;
        model_reset();
        chk("async count", int'(cnt[2]), 0);
        chk("async state", int'(st[2]), S_IDLE);
        chk("async busy", int'(bsy[2]), 0);
        chk("async done", int'(dn[2]), 0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b1;
    endtask

    task automatic set_in(input bit s, input bit p, input bit r, input bit t);
        start = s; progressive = p; regressive = r; stop = t;
    endtask

    typedef struct {
        bit s; bit p; bit r; bit t;
        int rep;
        int es; int ec; int ed;
    } vec_t;

    function automatic vec_t mkv(input bit s, input bit p, input bit r, input bit t,
                                 input int rep, input int es, input int ec, input int ed);
        vec_t v;
        v.s = s; v.p = p; v.r = r; v.t = t; v.rep = rep; v.es = es; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   ex_c [9];
        int   ex_s [9];
        int   ex_d [9];

        // Expected behaviour of the DWELL=1, TOP=15 instance, starting from HOLD at 0.
        tbl.push_back(mkv(0, 0, 1, 0, 1, S_HOLD, 0, 0));   // regressive at 0 ignored
        tbl.push_back(mkv(1, 0, 0, 0, 1, S_UP, 0, 0));
        for (int k = 1; k <= 7; k++) tbl.push_back(mkv(0, 0, 0, 0, 1, S_UP, k, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 1, S_DN, 7, 0));      // reversal holds count
        for (int k = 6; k >= 4; k--) tbl.push_back(mkv(0, 0, 0, 0, 1, S_DN, k, 0));
        tbl.push_back(mkv(0, 1, 0, 0, 1, S_UP, 4, 0));
        for (int k = 5; k <= 9; k++) tbl.push_back(mkv(0, 0, 0, 0, 1, S_UP, k, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 1, S_HOLD, 9, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 10, S_HOLD, 9, 0));
        tbl.push_back(mkv(0, 1, 0, 0, 1, S_UP, 9, 0));
        for (int k = 10; k <= 14; k++) tbl.push_back(mkv(0, 0, 0, 0, 1, S_UP, k, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, S_DN, 15, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 1, S_HOLD, 15, 0));
        tbl.push_back(mkv(0, 1, 1, 0, 1, S_DN, 15, 0));     // progressive ignored at TOP
        tbl.push_back(mkv(0, 0, 0, 0, 1, S_DN, 14, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 1, S_HOLD, 14, 0));
        tbl.push_back(mkv(1, 1, 0, 0, 1, S_UP, 0, 0));      // start wins in HOLD
        tbl.push_back(mkv(0, 0, 0, 1, 1, S_HOLD, 0, 0));
        tbl.push_back(mkv(0, 1, 0, 0, 1, S_UP, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, S_UP, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 0, 1, S_UP, 2, 0));      // start ignored in UP
        tbl.push_back(mkv(0, 0, 0, 1, 1, S_HOLD, 2, 0));

        if (AUTO) begin
            ex_c = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
            ex_s = '{S_UP, S_UP, S_UP, S_DN, S_DN, S_DN, S_UP, S_UP, S_UP};
        end else begin
            ex_c = '{0, 1, 2, 3, 2, 1, 0, 0, 0};
            ex_s = '{S_UP, S_UP, S_UP, S_DN, S_DN, S_DN, S_HOLD, S_HOLD, S_HOLD};
        end
        ex_d = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

        model_reset();
        #1 reset = 1'b0;
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b1;
        cyc();
        cyc();

        // Full single sweep on the DWELL=2, TOP=15 instance.
        set_in(1, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0);
        chk("sweep start state", int'(st[0]), S_UP);
        chk("sweep start count", int'(cnt[0]), 0);
        repeat (29) cyc();
        chk("sweep pre-top count", int'(cnt[0]), 14);
        cyc();
        chk("sweep top count", int'(cnt[0]), 15);
        chk("sweep top state", int'(st[0]), S_DN);
        repeat (29) cyc();
        chk("sweep last count", int'(cnt[0]), 1);
        chk("sweep last done", int'(dn[0]), 0);
        cyc();
        chk("sweep end count", int'(cnt[0]), 0);
        chk("sweep end state", int'(st[0]), S_HOLD);
        chk("sweep end done", int'(dn[0]), 1);
        chk("sweep end busy", int'(bsy[0]), 0);
        cyc();
        chk("sweep done width", int'(dn[0]), 0);

        // Table: reversal, stop/resume, boundary and priority on DWELL=1.
        foreach (tbl[k]) begin
            set_in(tbl[k].s, tbl[k].p, tbl[k].r, tbl[k].t);
            for (int r = 0; r < tbl[k].rep; r++) begin
                cyc();
                chk($sformatf("tbl%0d state", k), int'(st[1]), tbl[k].es);
                chk($sformatf("tbl%0d count", k), int'(cnt[1]), tbl[k].ec);
                chk($sformatf("tbl%0d done", k), int'(dn[1]), tbl[k].ed);
            end
        end
        set_in(0, 0, 0, 0);

        // Async reset during DOWN at count 5 on the DWELL=3, TOP=9 instance.
        do_async_reset();
        set_in(1, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0);
        repeat (38) cyc();
        chk("rst pre count", int'(cnt[2]), 6);
        cyc();
        chk("rst at count", int'(cnt[2]), 5);
        chk("rst at state", int'(st[2]), S_DN);
        do_async_reset();
        repeat (5) cyc();
        chk("rst idle state", int'(st[2]), S_IDLE);
        chk("rst idle count", int'(cnt[2]), 0);

        // Triangle / end-of-sweep on the TOP=3 instance.
        set_in(1, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            cyc();
            set_in(0, 0, 0, 0);
            chk($sformatf("tri%0d count", k), int'(cnt[3]), ex_c[k]);
            chk($sformatf("tri%0d state", k), int'(st[3]), ex_s[k]);
            chk($sformatf("tri%0d done", k), int'(dn[3]), ex_d[k]);
        end
        set_in(0, 0, 0, 1);
        cyc();
        set_in(0, 0, 0, 0);
        chk("tri stop state", int'(st[3]), S_HOLD);
        chk("tri stop count", int'(cnt[3]), AUTO ? 2 : 0);

        // Randomised traffic against the model, with quiet and busy stretches.
        for (int n = 0; n < 3000; n++) begin
            int lim;
            lim = ((n / 250) % 2 == 0) ? 40 : 8;
            start       = ($urandom_range(0, lim * 2) == 0);
            stop        = ($urandom_range(0, lim * 2) == 0);
            progressive = ($urandom_range(0, lim) == 0);
            regressive  = ($urandom_range(0, lim) == 0);
            if ($urandom_range(0, 499) == 0) do_async_reset();
            else cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
- Parametrised up/down sweep sequencer: an IDLE/UP/DOWN/HOLD state machine driving an internal WIDTH-bit counter.
- A dwell prescaler sets the step rate.
- Successor to the fixed 4-bit start/progressive/regressive controller. Adds configurable width, top value and step rate, mid-sweep reversal, stop, and a completion pulse.
- Sits between the push-button/debounce front end and the VGA pattern/colour logic, which consumes count and state.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- TOP, 15, sweep upper limit; 1 <= TOP <= 2^WIDTH-1.
- DWELL, 1, clock cycles per count step (>=1); prescaler width is max(1, clog2(DWELL)).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep from 0 (level, sampled each cycle).
- progressive  input  1  request upward sweep.
- regressive  input  1  request downward sweep.
- stop  input  1  freeze sweep in HOLD.
- count  output  WIDTH  current sweep value, registered.
- state  output  2  00 IDLE, 01 UP, 10 DOWN, 11 HOLD, registered.
- busy  output  1  high in UP or DOWN, registered.
- done  output  1  one-cycle pulse when a DOWN sweep reaches 0.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, prescaler=0, busy=0, done=0. Outputs hold these values until the first clk edge after reset is released.
- Reset asserted mid-sweep aborts immediately to the reset values; no done pulse.
- tick = (prescaler == DWELL-1) while in UP or DOWN.
  - prescaler increments each cycle in UP/DOWN, wraps to 0 on tick.
  - prescaler clears to 0 on every state change and in IDLE/HOLD.
  - With DWELL=1, tick is high every UP/DOWN cycle.
- Per-cycle priority in UP/DOWN: stop > direction request > tick.
- IDLE:
  - start=1 -> UP with count=0.
  - progressive, regressive and stop are ignored.
- UP:
  - stop=1 -> HOLD; count frozen.
  - regressive=1 (progressive=0) -> DOWN; count unchanged that cycle.
  - Otherwise on tick: count<=count+1. If count+1==TOP, next state is DOWN.
- DOWN:
  - stop=1 -> HOLD.
  - progressive=1 -> UP; count unchanged that cycle.
  - Otherwise on tick: count<=count-1. If count-1==0, next state is HOLD and done=1 for exactly that transition cycle.
- HOLD:
  - start=1 -> UP with count=0 (restart, highest priority).
  - Else progressive=1 and count<TOP -> UP.
  - Else regressive=1 and count>0 -> DOWN.
  - Requests at a boundary are ignored and the block stays in HOLD.
  - progressive and regressive both high: progressive wins.
- start is ignored in UP and DOWN.
- count never leaves 0..TOP; no wrap-around under any input sequence.
- busy = (state==UP || state==DOWN), registered alongside state.
- done is never asserted by stop, by reversal, or by reset.

Optional Feature:
- Macro: SWEEP_AUTO_REPEAT_EN.
- Defined: a DOWN tick that reaches 0 goes to UP instead of HOLD, producing a continuous triangle sweep 0..TOP..0.
  - done still pulses one cycle at each 0 crossing.
  - Only stop (-> HOLD) or reset ends the sweep.
- Not defined: the DOWN-to-0 transition goes to HOLD as specified in Behaviour.

Test Plan:
- Full single sweep, WIDTH=4, TOP=15, DWELL=2: reset released, start pulsed 1 cycle.
  - Expect state=UP, then count increments every 2 cycles.
  - count=15 with state=DOWN after 30 cycles in UP.
  - Then decrements to 0; done high exactly 1 cycle as state becomes HOLD; busy=0 after.
- Mid-sweep reversal, DWELL=1: at count=7 in UP, pulse regressive.
  - Expect state=DOWN next cycle with count=7, then 6,5,...
  - Then pulse progressive at count=4 -> UP with count=4, then 5.
- Stop and resume, DWELL=1: stop at count=9 in UP.
  - Expect HOLD with count=9 held for 10 cycles.
  - progressive -> UP, continues at 10.
  - In HOLD at count=0, regressive -> remains HOLD, count=0, done=0.
- Boundary/priority, DWELL=1: in HOLD at count=15, assert progressive and regressive together.
  - Expect DOWN (progressive ignored at TOP).
  - In HOLD, start with progressive -> UP with count=0.
- Async reset mid-operation, DWELL=3: assert reset between clk edges during DOWN at count=5.
  - Expect count=0, state=IDLE, busy=0 immediately, with no done pulse.
  - After release, outputs hold until start.
- SWEEP_AUTO_REPEAT_EN defined, TOP=3, DWELL=1: start.
  - Expect count sequence 0,1,2,3,2,1,0,1,2,... with done on each 0 crossing.
  - stop at count=2 -> HOLD, count=2.
